// File: rtl/vga_pixel_sequencer_if.sv
// Signal bundle between the raster sequencer and its pixel-tick, sprite-control and VGA-output side.
interface vga_pixel_sequencer_if;
  localparam int unsigned COORD_W = 10;
  localparam int unsigned SEL_W   = 3;

  logic               pix_en;
  logic [COORD_W-1:0] sprite_x;
  logic [COORD_W-1:0] sprite_y;
  logic               sprite_load;
  logic               sprite_ack;
  logic               hsync;
  logic               vsync;
  logic               blank_n;
  logic               frame_start;
  logic [SEL_W-1:0]   selector;

  modport master (
    output pix_en, sprite_x, sprite_y, sprite_load,
    input  sprite_ack, hsync, vsync, blank_n, frame_start, selector
  );

  modport slave (
    input  pix_en, sprite_x, sprite_y, sprite_load,
    output sprite_ack, hsync, vsync, blank_n, frame_start, selector
  );
endinterface

// File: rtl/vga_pixel_sequencer.sv
// Raster-scan sync generator and per-pixel colour-mux selector with a frame-synchronous,
// double-buffered sprite position.
module vga_pixel_sequencer #(
  parameter int unsigned H_VISIBLE   = 640,
  parameter int unsigned H_FP        = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BP        = 48,
  parameter int unsigned V_VISIBLE   = 480,
  parameter int unsigned V_FP        = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BP        = 33,
  parameter int unsigned LINE_W      = 4,
  parameter int unsigned SPRITE_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  vga_pixel_sequencer_if.slave bus
);
  localparam int unsigned CW = 11;

  localparam logic [CW-1:0] H_LAST = CW'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [CW-1:0] HS_BEG = CW'(H_VISIBLE + H_FP);
  localparam logic [CW-1:0] HS_END = CW'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_BEG = CW'(V_VISIBLE + V_FP);
  localparam logic [CW-1:0] VS_END = CW'(V_VISIBLE + V_FP + V_SYNC);
  localparam logic [CW-1:0] H_VIS  = CW'(H_VISIBLE);
  localparam logic [CW-1:0] V_VIS  = CW'(V_VISIBLE);
  // Board grid splits the visible area into thirds (213/426, 160/320 at 640x480).
  localparam logic [CW-1:0] GX1    = CW'(H_VISIBLE / 3);
  localparam logic [CW-1:0] GX2    = CW'(2 * (H_VISIBLE / 3));
  localparam logic [CW-1:0] GY1    = CW'(V_VISIBLE / 3);
  localparam logic [CW-1:0] GY2    = CW'(2 * (V_VISIBLE / 3));
  localparam logic [CW-1:0] LW     = CW'(LINE_W);
  localparam logic [CW-1:0] SS     = CW'(SPRITE_SIZE);
  localparam logic [CW-1:0] HB     = CW'(H_VISIBLE - LINE_W);
  localparam logic [CW-1:0] VB     = CW'(V_VISIBLE - LINE_W);
  localparam logic [CW-1:0] SX_MAX = CW'(H_VISIBLE - SPRITE_SIZE);
  localparam logic [CW-1:0] SY_MAX = CW'(V_VISIBLE - SPRITE_SIZE);

  localparam logic [2:0] SEL_BG     = 3'b000;
  localparam logic [2:0] SEL_BLACK  = 3'b001;
  localparam logic [2:0] SEL_GRID   = 3'b010;
  localparam logic [2:0] SEL_SPRITE = 3'b011;
  localparam logic [2:0] SEL_BORDER = 3'b110;

  typedef enum logic [1:0] {IDLE, PENDING, APPLY} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] hcount, vcount;
  logic [CW-1:0] shadow_x, shadow_y, live_x, live_y;
  logic          sprite_live;

  logic          h_last_c, wrap_c, live_c;
  logic [CW-1:0] req_x_c, req_y_c, pos_x_c, pos_y_c;
  logic          visible_c, in_sprite_c, on_grid_c, on_border_c;
  logic [2:0]    sel_c;

  assign h_last_c = (hcount == H_LAST);
  assign wrap_c   = bus.pix_en && h_last_c && (vcount == V_LAST);

  assign req_x_c  = (CW'(bus.sprite_x) > SX_MAX) ? SX_MAX : CW'(bus.sprite_x);
  assign req_y_c  = (CW'(bus.sprite_y) > SY_MAX) ? SY_MAX : CW'(bus.sprite_y);

  // During APPLY the shadow is already the position of the frame now starting.
  assign pos_x_c  = (state == APPLY) ? shadow_x : live_x;
  assign pos_y_c  = (state == APPLY) ? shadow_y : live_y;
  assign live_c   = sprite_live || (state == APPLY);

  always_comb begin
    sel_c       = SEL_BG;
    visible_c   = (hcount < H_VIS) && (vcount < V_VIS);
    in_sprite_c = live_c && (hcount >= pos_x_c) && (hcount < pos_x_c + SS)
                         && (vcount >= pos_y_c) && (vcount < pos_y_c + SS);
    on_grid_c   = ((hcount >= GX1) && (hcount < GX1 + LW)) || ((hcount >= GX2) && (hcount < GX2 + LW))
               || ((vcount >= GY1) && (vcount < GY1 + LW)) || ((vcount >= GY2) && (vcount < GY2 + LW));
    on_border_c = (hcount < LW) || (hcount >= HB) || (vcount < LW) || (vcount >= VB);
    if (!visible_c)       sel_c = SEL_BLACK;
    else if (in_sprite_c) sel_c = SEL_SPRITE;
    else if (on_grid_c)   sel_c = SEL_GRID;
    else if (on_border_c) sel_c = SEL_BORDER;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.sprite_load) state_nx = PENDING;
      PENDING: if (wrap_c)          state_nx = APPLY;
      APPLY:   state_nx = bus.sprite_load ? PENDING : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Shadow captures every load; live follows it only in the one-clk APPLY slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_x       <= '0;
      shadow_y       <= '0;
      live_x         <= '0;
      live_y         <= '0;
      sprite_live    <= 1'b0;
      bus.sprite_ack <= 1'b0;
    end else begin
      if (bus.sprite_load) begin
        shadow_x <= req_x_c;
        shadow_y <= req_y_c;
      end
      if (state == APPLY) begin
        live_x      <= shadow_x;
        live_y      <= shadow_y;
        sprite_live <= 1'b1;
      end
      bus.sprite_ack <= (state_nx == APPLY);
    end
  end

  // Raster counters and video outputs, one clk behind the counter they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcount          <= '0;
      vcount          <= '0;
      bus.hsync       <= 1'b1;
      bus.vsync       <= 1'b1;
      bus.blank_n     <= 1'b0;
      bus.selector    <= SEL_BLACK;
      bus.frame_start <= 1'b0;
    end else begin
      bus.frame_start <= wrap_c;
      if (bus.pix_en) begin
        bus.hsync    <= !((hcount >= HS_BEG) && (hcount < HS_END));
        bus.vsync    <= !((vcount >= VS_BEG) && (vcount < VS_END));
        bus.blank_n  <= visible_c;
        bus.selector <= sel_c;
        if (h_last_c) begin
          hcount <= '0;
          vcount <= (vcount == V_LAST) ? '0 : vcount + CW'(1);
        end else begin
          hcount <= hcount + CW'(1);
        end
      end
    end
  end
endmodule

// File: doc/vga_pixel_sequencer.md
# vga_pixel_sequencer

Raster-scan controller that drives the 3-bit `selector` of the colour mux feeding the VGA DAC. It generates 640x480@60 Hz sync timing from a pixel-enable tick. Every visible pixel is classified as background, board grid line, screen border or sprite. A double-buffered sprite position register updates only at frame boundaries, so the sprite never tears.

## Interface
Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porch and sync widths
- V_VISIBLE, 480, visible lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch and sync widths
- LINE_W, 4, grid and border line thickness in pixels
- SPRITE_SIZE, 32, sprite square edge in pixels

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- pix_en  in  1  pixel tick; one-clk pulse per pixel (25 MHz rate)
- sprite_x  in  10  requested sprite left edge
- sprite_y  in  10  requested sprite top edge
- sprite_load  in  1  one-clk request to latch sprite_x/sprite_y
- sprite_ack  out  1  one-clk pulse when the latched position becomes live
- hsync  out  1  horizontal sync, active-low
- vsync  out  1  vertical sync, active-low
- blank_n  out  1  high in the visible area
- frame_start  out  1  one-clk pulse at pixel (0,0)
- selector  out  3  colour mux code

## Operation
- Counters: hcount 0..799 and vcount 0..524 (totals computed from the parameters). They advance only on pix_en. hcount wraps to 0 and increments vcount. vcount wraps to 0 after 524.
- hsync is low while hcount is in [H_VISIBLE+H_FP, H_VISIBLE+H_FP+H_SYNC). vsync uses the same rule on vcount.
- Pixel classification, highest priority first:
  - not visible -> 001 (black)
  - sprite_live and x in [sx, sx+SPRITE_SIZE) and y in [sy, sy+SPRITE_SIZE) -> 011
  - grid line -> 010; x in [213, 213+LINE_W) or [426, 426+LINE_W), or y in [160, 160+LINE_W) or [320, 320+LINE_W)
  - border -> 110; x<LINE_W, x>=H_VISIBLE-LINE_W, y<LINE_W, or y>=V_VISIBLE-LINE_W
  - otherwise -> 000 (background)
- Codes 100, 101 and 111 are never emitted.
- Sprite load FSM, states IDLE, PENDING, APPLY:
  - IDLE: sprite_load latches the inputs into a shadow register -> PENDING.
  - PENDING: a further sprite_load overwrites the shadow (last write wins, one ack only). On the pix_en at which hcount=799 and vcount=524 -> APPLY.
  - APPLY, one clk: shadow is copied to live, sprite_live is set, sprite_ack=1 -> IDLE. A sprite_load arriving in APPLY is latched into the shadow -> PENDING.
- Clamp at latch time: sprite_x > H_VISIBLE-SPRITE_SIZE is stored as H_VISIBLE-SPRITE_SIZE. sprite_y is clamped the same way against V_VISIBLE.
- Reset values: counters 0, hsync=1, vsync=1, blank_n=0, selector=001, frame_start=0, sprite_ack=0, sprite_live=0, FSM=IDLE, shadow=0.
- Reset mid-frame or mid-PENDING discards the pending position with no ack. Output restarts from pixel (0,0).

## Timing
- All outputs are registered. hsync, vsync, blank_n and selector for counter value (h,v) are updated on the same clk edge on which pix_en samples (h,v), giving 1-clk latency from counter to output.
- Outputs hold between pix_en pulses. The colour mux adds one further registered clk; the board-level sync delay already accounts for it.
- frame_start pulses on the clk after the counters wrap to (0,0).
- Live sprite position changes only between frames, so the first pixel of the new frame uses the new position.
- sprite_ack occurs at most once per frame. Worst-case load-to-ack latency is one full frame plus 1 clk.
- If pix_en is held low, counters and outputs freeze. The FSM still accepts loads but cannot apply them.

## Test plan
- Reset released, pix_en every 4th clk for 2 frames: hsync is low for exactly 96 pix_en per line, vsync is low for lines 490-491, frame_start pulses once per 420000 pix_en.
- No sprite loaded, line y=100 is scanned: selector is 110 for x 0-3 and 636-639, 010 for x 213-216 and 426-429, 000 elsewhere, 001 for x>=640.
- sprite_load with (300,200) mid-frame: the current frame shows no 011; the next frame shows 011 for x 300-331 on y 200-231; sprite_ack pulses once at the wrap.
- Two loads in one frame, (10,10) then (50,60): only (50,60) appears, with a single ack.
- Load (700,470): the sprite appears at (608,448).
- Assert rst while PENDING at vcount=300: all outputs return to reset values asynchronously, no ack is given, and sprite_live stays 0 in the next frame.
